// File: rtl/snitch_data_mem_bist_pkg.sv
// Shared types and helpers for the TCDM built-in self test engine.
//   bist_mode_e  : run type latched at start (fill, check, fill then check)
//   bist_state_e : engine FSM states
//   clog2_min1   : $clog2 that never returns 0, so one-entry dimensions still get a 1-bit index
package snitch_data_mem_bist_pkg;

  typedef enum logic [1:0] {
    BIST_FILL       = 2'd0,
    BIST_CHECK      = 2'd1,
    BIST_FILL_CHECK = 2'd2
  } bist_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_data_mem_bist_if.sv
// Bank-array port bundle between the BIST engine and the TCDM banks.
//   cs/add/wen/be/wdata : per-bank request, driven by the initiator (master)
//   rdata               : per-bank read data, valid the cycle after a read request
interface snitch_data_mem_bist_if #(
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic [NumBanks-1:0]                cs;
  logic [NumBanks-1:0][AddrWidth-1:0] add;
  logic [NumBanks-1:0]                wen;
  logic [NumBanks-1:0][StrbWidth-1:0] be;
  logic [NumBanks-1:0][DataWidth-1:0] wdata;
  logic [NumBanks-1:0][DataWidth-1:0] rdata;

  modport master (output cs, add, wen, be, wdata, input rdata);
  modport slave  (input cs, add, wen, be, wdata, output rdata);
endinterface

// File: rtl/snitch_data_mem_bist_cmp.sv
// Combinational read-data checker.
//   valid_i      : a read response is present this cycle
//   expected_i   : word every bank should return
//   rdata_i      : per-bank read data
//   mismatch_o   : per-bank mismatch flags (0 when not valid)
//   any_o        : at least one bank mismatched
//   first_bank_o : lowest mismatching bank index
//   popcnt_o     : number of mismatching banks
module snitch_data_mem_bist_cmp
  import snitch_data_mem_bist_pkg::*;
#(
  parameter int unsigned NumBanks     = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned BankIdxWidth = clog2_min1(NumBanks),
  parameter int unsigned PopWidth     = $clog2(NumBanks + 1)
) (
  input  logic                               valid_i,
  input  logic [DataWidth-1:0]               expected_i,
  input  logic [NumBanks-1:0][DataWidth-1:0] rdata_i,
  output logic [NumBanks-1:0]                mismatch_o,
  output logic                               any_o,
  output logic [BankIdxWidth-1:0]            first_bank_o,
  output logic [PopWidth-1:0]                popcnt_o
);

  for (genvar gi = 0; gi < NumBanks; gi++) begin : g_cmp
    assign mismatch_o[gi] = valid_i && (rdata_i[gi] != expected_i);
  end

  assign any_o = |mismatch_o;

  // Walk from the top so the lowest failing bank is the last assignment.
  always_comb begin
    first_bank_o = '0;
    for (int i = NumBanks - 1; i >= 0; i--) begin
      if (mismatch_o[i]) first_bank_o = BankIdxWidth'(i);
    end
  end

  always_comb begin
    popcnt_o = '0;
    for (int i = 0; i < NumBanks; i++) begin
      popcnt_o = popcnt_o + PopWidth'(mismatch_o[i]);
    end
  end

endmodule

// File: rtl/snitch_data_mem_bist.sv
// TCDM memory BIST initiator: fills all banks in lock-step with a pattern,
// checks them, or both, while owning the bank ports (busy_o=1).
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i            : start request, only honoured in IDLE
//   mode_i             : 0 fill, 1 check, 2/3 fill then check
//   pattern_i          : base data pattern
//   addr_xor_i         : xor the replicated row address into every word
//   busy_o, done_o     : engine active / one-cycle completion pulse
//   pass_o             : last run had zero mismatching words
//   err_bank_o/addr_o  : location of the first mismatch of the run
//   err_cnt_o          : saturating count of mismatching words
//   bank_if            : per-bank request/response bundle (master side)
module snitch_data_mem_bist
  import snitch_data_mem_bist_pkg::*;
#(
  parameter int unsigned TCDMDepth       = 1024,
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned NumTotalBanks   = 32,
  parameter int unsigned ErrCntWidth     = 16,
  // Width of tcdm_mem_addr_t; must be >= the row index width.
  parameter int unsigned MemAddrWidth    = clog2_min1(TCDMDepth),
  localparam int unsigned AddrWidth      = clog2_min1(TCDMDepth),
  localparam int unsigned BankIdxWidth   = clog2_min1(NumTotalBanks)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [1:0]                  mode_i,
  input  logic [NarrowDataWidth-1:0]  pattern_i,
  input  logic                        addr_xor_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic [BankIdxWidth-1:0]     err_bank_o,
  output logic [AddrWidth-1:0]        err_addr_o,
  output logic [ErrCntWidth-1:0]      err_cnt_o,
  snitch_data_mem_bist_if.master      bank_if
);

  localparam int unsigned StrbWidth = NarrowDataWidth / 8;
  localparam int unsigned PopWidth  = $clog2(NumTotalBanks + 1);
  localparam int unsigned SumWidth  = ((ErrCntWidth > PopWidth) ? ErrCntWidth : PopWidth) + 1;

  typedef logic [NarrowDataWidth-1:0] data_t;
  typedef logic [MemAddrWidth-1:0]    tcdm_mem_addr_t;
  typedef logic [AddrWidth-1:0]       row_t;

  localparam row_t                   LastRow = row_t'(TCDMDepth - 1);
  localparam logic [ErrCntWidth-1:0] CntMax  = '1;

  // Row address zero-extended to the bank address type, then tiled across
  // the word (truncated at the top) and xored into the pattern.
  function automatic data_t pattern_word(input data_t pat, input logic do_xor, input row_t r);
    tcdm_mem_addr_t ext;
    data_t          rep;
    ext = tcdm_mem_addr_t'(r);
    for (int i = 0; i < NarrowDataWidth; i++) rep[i] = ext[i % MemAddrWidth];
    return do_xor ? (pat ^ rep) : pat;
  endfunction

  bist_state_e              state_q, state_d;
  bist_mode_e               mode_q, mode_d;
  data_t                    pattern_q, pattern_d;
  logic                     xor_q, xor_d;
  row_t                     row_q, row_d;
  logic                     rd_vld_q, rd_vld_d;
  row_t                     rd_row_q, rd_row_d;
  logic                     pass_q, pass_d;
  logic [BankIdxWidth-1:0]  err_bank_q, err_bank_d;
  row_t                     err_addr_q, err_addr_d;
  logic [ErrCntWidth-1:0]   err_cnt_q, err_cnt_d;

  logic [NumTotalBanks-1:0] mismatch;
  logic                     cmp_any;
  logic [BankIdxWidth-1:0]  cmp_first;
  logic [PopWidth-1:0]      cmp_popcnt;
  logic [SumWidth-1:0]      cnt_sum;
  data_t                    exp_word;
  data_t                    wr_word;
  logic                     access;
  logic                     is_write;

  // Response of the read issued last cycle is checked against the word
  // that belongs to its tagged row.
  assign exp_word = pattern_word(pattern_q, xor_q, rd_row_q);

  snitch_data_mem_bist_cmp #(
    .NumBanks     (NumTotalBanks),
    .DataWidth    (NarrowDataWidth),
    .BankIdxWidth (BankIdxWidth),
    .PopWidth     (PopWidth)
  ) i_cmp (
    .valid_i      (rd_vld_q),
    .expected_i   (exp_word),
    .rdata_i      (bank_if.rdata),
    .mismatch_o   (mismatch),
    .any_o        (cmp_any),
    .first_bank_o (cmp_first),
    .popcnt_o     (cmp_popcnt)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pattern_d  = pattern_q;
    xor_d      = xor_q;
    row_d      = row_q;
    rd_vld_d   = 1'b0;
    rd_row_d   = rd_row_q;
    pass_d     = pass_q;
    err_bank_d = err_bank_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    cnt_sum    = SumWidth'(err_cnt_q) + SumWidth'(cmp_popcnt);

    if (cmp_any) begin
      // pass_q still set means no earlier mismatch in this run.
      if (pass_q) begin
        err_bank_d = cmp_first;
        err_addr_d = rd_row_q;
      end
      pass_d    = 1'b0;
      err_cnt_d = (cnt_sum > SumWidth'(CntMax)) ? CntMax : ErrCntWidth'(cnt_sum);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (mode_i)
            2'd0:    mode_d = BIST_FILL;
            2'd1:    mode_d = BIST_CHECK;
            default: mode_d = BIST_FILL_CHECK;
          endcase
          pattern_d  = pattern_i;
          xor_d      = addr_xor_i;
          row_d      = '0;
          pass_d     = 1'b1;
          err_bank_d = '0;
          err_addr_d = '0;
          err_cnt_d  = '0;
          state_d    = (mode_i == 2'd1) ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = (mode_q == BIST_FILL) ? ST_DONE : ST_READ;
        end else begin
          row_d = row_q + row_t'(1);
        end
      end
      ST_READ: begin
        rd_vld_d = 1'b1;
        rd_row_d = row_q;
        if (row_q == LastRow) begin
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          row_d = row_q + row_t'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      mode_q     <= BIST_FILL;
      pattern_q  <= '0;
      xor_q      <= 1'b0;
      row_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_row_q   <= '0;
      pass_q     <= 1'b1;
      err_bank_q <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pattern_q  <= pattern_d;
      xor_q      <= xor_d;
      row_q      <= row_d;
      rd_vld_q   <= rd_vld_d;
      rd_row_q   <= rd_row_d;
      pass_q     <= pass_d;
      err_bank_q <= err_bank_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Bank requests decode from registered state only, so reset drops cs at once.
  assign access   = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign is_write = (state_q == ST_WRITE);
  assign wr_word  = pattern_word(pattern_q, xor_q, row_q);

  for (genvar gi = 0; gi < NumTotalBanks; gi++) begin : g_bank
    assign bank_if.cs[gi]    = access;
    assign bank_if.wen[gi]   = is_write;
    assign bank_if.be[gi]    = {StrbWidth{is_write}};
    assign bank_if.add[gi]   = tcdm_mem_addr_t'(row_q);
    assign bank_if.wdata[gi] = wr_word;
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign pass_o     = pass_q;
  assign err_bank_o = err_bank_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_snitch_data_mem_bist.sv
// Directed bench for snitch_data_mem_bist: 16 rows x 4 banks x 64 bits,
// behavioural 1-cycle SRAM, plus a second engine with a 4-bit error counter
// whose read data is stuck at all ones.
module tb_snitch_data_mem_bist;
  import snitch_data_mem_bist_pkg::*;

  localparam int D   = 16;
  localparam int NB  = 4;
  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int MAW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, start_s = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] pattern = '0;
  logic          axor = 1'b0;
  logic          busy, done, pass;
  logic [1:0]    err_bank;
  logic [AW-1:0] err_addr;
  logic [15:0]   err_cnt;
  logic          busy_s, done_s, pass_s;
  logic [1:0]    err_bank_s;
  logic [AW-1:0] err_addr_s;
  logic [3:0]    err_cnt_s;

  snitch_data_mem_bist_if #(.NumBanks(NB), .AddrWidth(MAW), .DataWidth(DW)) mem_if ();
  snitch_data_mem_bist_if #(.NumBanks(NB), .AddrWidth(MAW), .DataWidth(DW)) sat_if ();

  snitch_data_mem_bist #(
    .TCDMDepth(D), .NarrowDataWidth(DW), .NumTotalBanks(NB), .ErrCntWidth(16), .MemAddrWidth(MAW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .pattern_i(pattern),
    .addr_xor_i(axor), .busy_o(busy), .done_o(done), .pass_o(pass), .err_bank_o(err_bank),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt), .bank_if(mem_if)
  );

  snitch_data_mem_bist #(
    .TCDMDepth(D), .NarrowDataWidth(DW), .NumTotalBanks(NB), .ErrCntWidth(4), .MemAddrWidth(MAW)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .mode_i(mode), .pattern_i(pattern),
    .addr_xor_i(axor), .busy_o(busy_s), .done_o(done_s), .pass_o(pass_s), .err_bank_o(err_bank_s),
    .err_addr_o(err_addr_s), .err_cnt_o(err_cnt_s), .bank_if(sat_if)
  );

  assign sat_if.rdata = '1;

  // Behavioural SRAM with 1-cycle read latency and write bookkeeping.
  logic [DW-1:0]          mem_arr [NB][D];
  logic [NB-1:0][DW-1:0]  rdata_q;
  int                     wr_cnt [NB];
  int                     be_bad;
  int                     add_bad;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_if.cs[b]) begin
        if (mem_if.add[b][MAW-1:AW] != '0) add_bad = add_bad + 1;
        if (mem_if.wen[b]) begin
          wr_cnt[b] = wr_cnt[b] + 1;
          if (mem_if.be[b] != 8'hFF) be_bad = be_bad + 1;
          for (int k = 0; k < 8; k++)
            if (mem_if.be[b][k]) mem_arr[b][mem_if.add[b][AW-1:0]][k*8 +: 8] = mem_if.wdata[b][k*8 +: 8];
        end else begin
          rdata_q[b] <= mem_arr[b][mem_if.add[b][AW-1:0]];
        end
      end
    end
  end
  assign mem_if.rdata = rdata_q;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pw(input logic [DW-1:0] p, input logic x, input int r);
    logic [15:0] e;
    e = 16'(r);
    return x ? (p ^ {e, e, e, e}) : p;
  endfunction

  function automatic int model_bad(input logic [DW-1:0] p, input logic x);
    int n = 0;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < D; r++)
        if (mem_arr[b][r] !== pw(p, x, r)) n++;
    return n;
  endfunction

  // Start a run at a negedge; cycle 1 is the first cycle after the accepting edge.
  task automatic run_bist(input logic [1:0] m, input logic [DW-1:0] p, input logic x,
                          input int inject, output int done_cyc, output int n_done);
    @(negedge clk);
    mode = m; pattern = p; axor = x;
    for (int b = 0; b < NB; b++) wr_cnt[b] = 0;
    be_bad = 0; add_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    n_done = 0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc == inject) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] pat;
    logic          x;
    int            exp_done;
    logic          exp_pass;
    int            exp_cnt;
    int            exp_bank;
    int            exp_addr;
    int            exp_wr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int dc, nd, sat_done;
    vecs[0] = '{2'd0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 17, 1'b1, 0,  0, 0, 16};
    vecs[1] = '{2'd1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 18, 1'b1, 0,  0, 0, 0};
    vecs[2] = '{2'd2, 64'h0,                   1'b1, 34, 1'b1, 0,  0, 0, 16};
    vecs[3] = '{2'd1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 18, 1'b0, 64, 0, 0, 0};
    vecs[4] = '{2'd3, 64'h0123_4567_89AB_CDEF, 1'b1, 34, 1'b1, 0,  0, 0, 16};

    for (int b = 0; b < NB; b++) begin
      wr_cnt[b] = 0;
      for (int r = 0; r < D; r++) mem_arr[b][r] = '0;
    end
    be_bad = 0; add_bad = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", mem_if.cs, 0);
    chk("rst_wen", mem_if.wen, 0);
    chk("rst_pass", pass, 1);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_loc", {err_bank, err_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_bist(vecs[v].mode, vecs[v].pat, vecs[v].x, -1, dc, nd);
      $display("vec %0d mode=%0d done@%0d n_done=%0d pass=%0b cnt=%0d bank=%0d addr=%0d",
               v, vecs[v].mode, dc, nd, pass, err_cnt, err_bank, err_addr);
      chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
      chk($sformatf("v%0d_done_pulses", v), nd, 1);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, vecs[v].exp_cnt);
      chk($sformatf("v%0d_err_bank", v), err_bank, vecs[v].exp_bank);
      chk($sformatf("v%0d_err_addr", v), err_addr, vecs[v].exp_addr);
      for (int b = 0; b < NB; b++)
        chk($sformatf("v%0d_writes_b%0d", v, b), wr_cnt[b], vecs[v].exp_wr);
      chk($sformatf("v%0d_be", v), be_bad, 0);
      chk($sformatf("v%0d_addr_ext", v), add_bad, 0);
      if (vecs[v].mode != 2'd1)
        chk($sformatf("v%0d_mem_content", v), model_bad(vecs[v].pat, vecs[v].x), 0);
    end

    // Two corrupted words; first failure must be bank 2 row 5.
    @(negedge clk);
    mem_arr[2][5] = 64'hDEAD;
    mem_arr[1][9] = 64'h0;
    run_bist(2'd1, 64'h0123_4567_89AB_CDEF, 1'b1, -1, dc, nd);
    $display("corrupt check done@%0d pass=%0b cnt=%0d bank=%0d addr=%0d", dc, pass, err_cnt, err_bank, err_addr);
    chk("corr_done_cycle", dc, 18);
    chk("corr_pass", pass, 0);
    chk("corr_err_cnt", err_cnt, 2);
    chk("corr_err_bank", err_bank, 2);
    chk("corr_err_addr", err_addr, 5);

    // Reset in cycle 8 of a check; row 5 mismatch is already recorded by then.
    @(negedge clk);
    mode = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", busy, 1);
    chk("mid_pass", pass, 0);
    chk("mid_err_cnt", err_cnt, 1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-check cs=%0h busy=%0b pass=%0b cnt=%0d", mem_if.cs, busy, pass, err_cnt);
    chk("arst_cs", mem_if.cs, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pass", pass, 1);
    chk("arst_err_cnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with a start pulse while busy; repairs the corrupted words.
    run_bist(2'd0, 64'h0123_4567_89AB_CDEF, 1'b1, 5, dc, nd);
    $display("fill with busy start done@%0d n_done=%0d writes=%0d", dc, nd, wr_cnt[0]);
    chk("busy_start_done_cycle", dc, 17);
    chk("busy_start_done_pulses", nd, 1);
    chk("busy_start_writes", wr_cnt[2], 16);
    chk("busy_start_busy_after", busy, 0);

    run_bist(2'd1, 64'h0123_4567_89AB_CDEF, 1'b1, -1, dc, nd);
    $display("post-reset check done@%0d pass=%0b cnt=%0d", dc, pass, err_cnt);
    chk("post_done_cycle", dc, 18);
    chk("post_pass", pass, 1);
    chk("post_err_cnt", err_cnt, 0);

    // Saturating counter: 64 mismatches into a 4-bit counter.
    @(negedge clk);
    mode = 2'd1; pattern = '0; axor = 1'b0; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    sat_done = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done_s) begin
        sat_done = c;
        break;
      end
      @(posedge clk); #1;
    end
    $display("saturation check done@%0d pass=%0b cnt=%0d bank=%0d addr=%0d", sat_done, pass_s, err_cnt_s, err_bank_s, err_addr_s);
    chk("sat_done_cycle", sat_done, 18);
    chk("sat_err_cnt", err_cnt_s, 15);
    chk("sat_pass", pass_s, 0);
    chk("sat_err_loc", {err_bank_s, err_addr_s}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
